// File: rtl/rom_stream_reader_if.sv
// rom_stream_reader_if: bus bundle for the ROM stream reader.
//   ROM side (Avalon-MM read): rom_address, rom_chipselect, rom_clken,
//     rom_byteenable, rom_write driven by the reader; rom_readdata returned by the ROM.
//   Stream side (valid/ready): st_data, st_valid, st_last driven by the reader;
//     st_ready returned by the consumer.
// modport master = the reader, modport slave = ROM + consumer side.
interface rom_stream_reader_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0]   rom_address;
    logic                rom_chipselect;
    logic                rom_clken;
    logic [DATA_W/8-1:0] rom_byteenable;
    logic                rom_write;
    logic [DATA_W-1:0]   rom_readdata;
    logic [DATA_W-1:0]   st_data;
    logic                st_valid;
    logic                st_ready;
    logic                st_last;

    modport master (
        output rom_address, rom_chipselect, rom_clken, rom_byteenable, rom_write,
        output st_data, st_valid, st_last,
        input  rom_readdata, st_ready
    );

    modport slave (
        input  rom_address, rom_chipselect, rom_clken, rom_byteenable, rom_write,
        input  st_data, st_valid, st_last,
        output rom_readdata, st_ready
    );
endinterface

// File: rtl/rom_stream_reader.sv
// rom_stream_reader: walks a (base, length) window of a 1-cycle-latency ROM and
// streams the words out through a small FIFO on a valid/ready interface.
// One-shot or looping playback, with an orderly stop that drains buffered words.
//
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   start/stop/loop      control pulses / loop mode (loop sampled at start)
//   base_addr, length    window, sampled at an accepted start (length 1..2^ADDR_W)
//   busy, done, err      status: busy window, end-of-playback pulse, bad-start pulse
//   checksum             running sum of streamed words (optional feature)
//   bus                  rom_stream_reader_if.master: ROM read port + output stream
//
// Optional feature macro: ROM_STREAM_READER_CHECKSUM_EN
//   defined   -> checksum = modulo-2^DATA_W sum of words transferred, cleared on
//                accepted start, frozen once playback is done
//   undefined -> checksum tied to 0
module rom_stream_reader #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 loop,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [ADDR_W:0]      length,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [DATA_W-1:0]    checksum,
    rom_stream_reader_if.master  bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } entry_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] ptr, base_q;
    logic [ADDR_W:0]   len_q, idx;
    logic              loop_q;
    logic              inflight, inflight_last;

    entry_t            mem [FIFO_DEPTH];
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [CW-1:0]     count;

    logic len_ok, start_ok, issue, pass_end, push, pop, fifo_empty;

    assign len_ok     = (length != '0) && (length <= MAX_LEN);
    assign pass_end   = (idx == len_q - 1'b1);
    assign fifo_empty = (count == '0);
    // The word issued last cycle is on rom_readdata now; it always has room
    // because issue only happens while occupancy + in-flight < FIFO_DEPTH.
    assign push       = inflight;
    assign pop        = bus.st_valid & bus.st_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        start_ok = 1'b0;
        issue    = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start && len_ok) begin
                    start_ok = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                // stop suppresses the issue in its own cycle as well
                if (stop) begin
                    state_nx = DRAIN;
                end else if ((count + CW'(inflight)) < DEPTH_C) begin
                    issue = 1'b1;
                    if (pass_end && !loop_q) state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (!inflight && fifo_empty) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // busy drops in the done cycle so the two edges line up
    assign busy = (state != IDLE) && !done;

    assign bus.rom_address    = ptr;
    assign bus.rom_chipselect = issue;
    assign bus.rom_clken      = busy;
    assign bus.rom_byteenable = '1;
    assign bus.rom_write      = 1'b0;
    assign bus.st_valid       = !fifo_empty;
    assign bus.st_data        = mem[rd_ptr].data;
    assign bus.st_last        = mem[rd_ptr].last;

    // window walker
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr           <= '0;
            base_q        <= '0;
            len_q         <= '0;
            idx           <= '0;
            loop_q        <= 1'b0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            err           <= 1'b0;
        end else begin
            err           <= start && (state == IDLE) && !len_ok;
            inflight      <= issue;
            inflight_last <= issue && pass_end;
            if (start_ok) begin
                ptr    <= base_addr;
                base_q <= base_addr;
                len_q  <= length;
                loop_q <= loop;
                idx    <= '0;
            end else if (issue) begin
                if (pass_end) begin
                    // reload for the next pass; harmless when not looping
                    ptr <= base_q;
                    idx <= '0;
                end else begin
                    ptr <= ptr + 1'b1;
                    idx <= idx + 1'b1;
                end
            end
        end
    end

    // output FIFO
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{last: inflight_last, data: bus.rom_readdata};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

`ifdef ROM_STREAM_READER_CHECKSUM_EN
    // pops only happen while busy, so the sum holds still after done
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      checksum <= '0;
        else if (start_ok) checksum <= '0;
        else if (pop)      checksum <= checksum + bus.st_data;
    end
`else
    assign checksum = '0;
`endif
endmodule
